// File: rtl/word_stream_pkg.sv
// Shared lane/state types for the word stream serializer and its deserializer partner.
package word_stream_pkg;

  localparam int LANES = 4;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

endpackage

// File: rtl/word_serializer_if.sv
// Word-in handshake plus FIFO write port of the word serializer.
// The slave modport is the serializer's view; the master modport drives it.
interface word_serializer_if
  import word_stream_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int POINTER_WIDTH = 8
);

  logic [DATA_WIDTH-1:0]    word_in [LANES-1:0];
  logic                     word_in_valid;
  logic                     word_in_ready;
  logic [POINTER_WIDTH-1:0] data_in_used;
  logic [DATA_WIDTH-1:0]    data_in;
  logic                     data_in_enable;
  logic                     busy;

  modport master (
    output word_in, word_in_valid, data_in_used,
    input  word_in_ready, data_in, data_in_enable, busy
  );

  modport slave (
    input  word_in, word_in_valid, data_in_used,
    output word_in_ready, data_in, data_in_enable, busy
  );

endinterface

// File: rtl/word_holding_reg.sv
// One-word skid register with full flag; ready is registered as the inverse of the next full state.
module word_holding_reg
  import word_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_word [LANES-1:0],
  input  logic                  pop,
  output logic                  full,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] word [LANES-1:0]
);

  logic                  full_q, full_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] word_q [LANES-1:0];
  logic [DATA_WIDTH-1:0] word_d [LANES-1:0];

  // A push is ignored while full so a held word can never be overwritten.
  always_comb begin
    full_d = full_q;
    word_d = word_q;
    if (pop) begin
      full_d = 1'b0;
    end
    if (push && !full_q) begin
      full_d = 1'b1;
      word_d = push_word;
    end
    ready_d = !full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      word_q  <= '{default: '0};
    end else begin
      full_q  <= full_d;
      ready_q <= ready_d;
      word_q  <= word_d;
    end
  end

  assign full  = full_q;
  assign ready = ready_q;
  assign word  = word_q;

endmodule

// File: rtl/word_serializer.sv
// Splits 4-lane words into one byte per cycle for the deserializer FIFO, stalling on its fill level.
// Optional macro WORD_SERIALIZER_STATS_EN adds the words_sent counter port.
module word_serializer
  import word_stream_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int POINTER_WIDTH  = 8,
  parameter int FULL_THRESHOLD = 2**POINTER_WIDTH - 4
) (
  input  logic               sender_clock,
  input  logic               reset,
  word_serializer_if.slave   bus
`ifdef WORD_SERIALIZER_STATS_EN
  ,
  output logic [15:0]        words_sent
`endif
);

  localparam logic [POINTER_WIDTH-1:0] FULL_LEVEL = POINTER_WIDTH'(FULL_THRESHOLD);
  localparam lane_idx_t                LAST_LANE  = lane_idx_t'(LANES - 1);

  state_t                state_q, state_d;
  lane_idx_t             lane_q, lane_d;
  logic [DATA_WIDTH-1:0] shifter_q [LANES-1:0];
  logic [DATA_WIDTH-1:0] shifter_d [LANES-1:0];
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  enable_q, enable_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic                  stall;
  logic                  last_emit;
  logic                  push;
  logic                  pop;
  logic                  hold_full;
  logic                  hold_ready;
  logic [DATA_WIDTH-1:0] hold_word [LANES-1:0];

  word_holding_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold (
    .clk      (sender_clock),
    .rst      (reset),
    .push     (push),
    .push_word(bus.word_in),
    .pop      (pop),
    .full     (hold_full),
    .ready    (hold_ready),
    .word     (hold_word)
  );

  assign accept    = bus.word_in_valid && hold_ready;
  assign stall     = (bus.data_in_used >= FULL_LEVEL);
  assign last_emit = (state_q == SEND) && !stall && (lane_q == LAST_LANE);

  // On the last lane the next word is taken from the holding register first, else straight from
  // the input, so consecutive words leave with no idle cycle between them.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    shifter_d = shifter_q;
    data_d    = data_q;
    enable_d  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        lane_d = '0;
        if (hold_full) begin
          shifter_d = hold_word;
          pop       = 1'b1;
          state_d   = SEND;
        end else if (accept) begin
          shifter_d = bus.word_in;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (!stall) begin
          data_d   = shifter_q[lane_q];
          enable_d = 1'b1;
          lane_d   = lane_q + 2'd1;
        end
        if (last_emit) begin
          if (hold_full) begin
            shifter_d = hold_word;
            pop       = 1'b1;
          end else if (accept) begin
            shifter_d = bus.word_in;
          end else begin
            state_d = IDLE;
          end
        end else begin
          push = accept;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SEND) || (hold_full && !pop) || push;
  end

  always_ff @(posedge sender_clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      shifter_q <= '{default: '0};
      data_q    <= '0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      shifter_q <= shifter_d;
      data_q    <= data_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.word_in_ready  = hold_ready;
  assign bus.data_in        = data_q;
  assign bus.data_in_enable = enable_q;
  assign bus.busy           = busy_q;

`ifdef WORD_SERIALIZER_STATS_EN
  logic [15:0] words_sent_q, words_sent_d;

  always_comb begin
    words_sent_d = words_sent_q;
    if (last_emit) begin
      words_sent_d = words_sent_q + 16'd1;
    end
  end

  always_ff @(posedge sender_clock or posedge reset) begin
    if (reset) begin
      words_sent_q <= '0;
    end else begin
      words_sent_q <= words_sent_d;
    end
  end

  assign words_sent = words_sent_q;
`endif

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: byte-queue reference model plus directed and random scenarios.
`timescale 1ns/1ps
module tb_word_serializer;
  import word_stream_pkg::*;

  localparam int DW = 8;
  localparam int PW = 8;
  localparam int FT = 2**PW - 4;
  localparam int RANDOM_WORDS = 4000;

  logic sender_clock = 1'b0;
  logic reset = 1'b1;

  word_serializer_if #(.DATA_WIDTH(DW), .POINTER_WIDTH(PW)) bus ();

`ifdef WORD_SERIALIZER_STATS_EN
  logic [15:0] words_sent;
`endif

  word_serializer #(
    .DATA_WIDTH    (DW),
    .POINTER_WIDTH (PW),
    .FULL_THRESHOLD(FT)
  ) dut (
    .sender_clock(sender_clock),
    .reset       (reset),
    .bus         (bus)
`ifdef WORD_SERIALIZER_STATS_EN
    ,
    .words_sent  (words_sent)
`endif
  );

  always #5 sender_clock = ~sender_clock;

  int assertions = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4*DW-1:0] w, input logic valid, input logic [PW-1:0] used);
    for (int i = 0; i < LANES; i++) begin
      bus.word_in[i] = w[i*DW +: DW];
    end
    bus.word_in_valid = valid;
    bus.data_in_used  = used;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with valid dropped.
  task automatic pushWord(input logic [4*DW-1:0] w);
    int guard;
    guard = 0;
    applyStimulus(w, 1'b1, bus.data_in_used);
    while (!bus.word_in_ready && guard < 200) begin
      @(negedge sender_clock);
      guard++;
    end
    if (guard >= 200) begin
      assertions++;
      failures++;
      $display("[TB] FAIL push_timeout: ready never rose, waited %0d cycles, limit 200", guard);
    end
    @(negedge sender_clock);
    bus.word_in_valid = 1'b0;
  endtask

  // Reference model: bytes accepted form a queue; one byte leaves per edge whenever bytes
  // accepted at earlier edges remain and the fill level is under the threshold.
  logic [DW-1:0] m_q[$];
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_last = '0;
  logic [DW-1:0] m_exp_byte;
  logic          m_acc;
  logic          m_en_exp;
  int            m_popped = 0;
  int            m_words = 0;
  int            m_outstanding = 0;

  always @(posedge sender_clock) begin
    if (reset) begin
      m_q.delete();
      m_ready       = 1'b0;
      m_last        = '0;
      m_popped      = 0;
      m_words       = 0;
      m_outstanding = 0;
    end else begin
      m_acc    = bus.word_in_valid && m_ready;
      m_en_exp = (m_q.size() > 0) && (int'(bus.data_in_used) < FT);
      if (m_en_exp) begin
        m_exp_byte = m_q.pop_front();
        m_last     = m_exp_byte;
        m_popped++;
        if (m_popped % LANES == 0) m_words++;
      end
      if (m_acc) begin
        for (int i = 0; i < LANES; i++) m_q.push_back(bus.word_in[i]);
      end
      m_outstanding = (m_q.size() + LANES - 1) / LANES;
      m_ready       = (m_outstanding < 2);
      #1;
      if (!reset) begin
        checkOutput("model_enable", {31'b0, bus.data_in_enable}, {31'b0, m_en_exp});
        checkOutput("model_data", {24'b0, bus.data_in}, {24'b0, m_last});
        checkOutput("model_ready", {31'b0, bus.word_in_ready}, {31'b0, m_ready});
        checkOutput("model_busy", {31'b0, bus.busy}, {31'b0, (m_outstanding > 0)});
`ifdef WORD_SERIALIZER_STATS_EN
        checkOutput("model_words_sent", {16'b0, words_sent}, {16'b0, 16'(m_words)});
`endif
      end
    end
  end

  int run_len = 0;
  int max_run = 0;
  int bytes_seen = 0;

  always @(negedge sender_clock) begin
    if (bus.data_in_enable && !reset) begin
      run_len++;
      bytes_seen++;
    end else begin
      run_len = 0;
    end
    if (run_len > max_run) max_run = run_len;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  int          sent;
  int          cycles;
  int          start_bytes;
  int          pick;
  logic        valid_r;
  logic [PW-1:0] used_r;
  logic [31:0] rand_word;

  initial begin
    applyStimulus('0, 1'b0, '0);
    reset = 1'b1;
    repeat (3) @(negedge sender_clock);
    checkOutput("reset_data", {24'b0, bus.data_in}, 32'h0);
    checkOutput("reset_enable", {31'b0, bus.data_in_enable}, 32'h0);
    checkOutput("reset_busy", {31'b0, bus.busy}, 32'h0);
    reset = 1'b0;
    @(negedge sender_clock);
    checkOutput("ready_after_reset", {31'b0, bus.word_in_ready}, 32'h1);

    $display("[TB] single word");
    pushWord(32'h03020100);
    checkOutput("t1_no_early_enable", {31'b0, bus.data_in_enable}, 32'h0);
    checkOutput("t1_busy_on_accept", {31'b0, bus.busy}, 32'h1);
    for (int i = 0; i < LANES; i++) begin
      @(negedge sender_clock);
      checkOutput("t1_lane_data", {24'b0, bus.data_in}, 32'(i));
      checkOutput("t1_lane_enable", {31'b0, bus.data_in_enable}, 32'h1);
    end
    checkOutput("t1_busy_done", {31'b0, bus.busy}, 32'h0);
    @(negedge sender_clock);
    checkOutput("t1_enable_idle", {31'b0, bus.data_in_enable}, 32'h0);
    repeat (2) @(negedge sender_clock);

    $display("[TB] back-to-back words");
    max_run = 0;
    pushWord(32'h13121110);
    pushWord(32'h17161514);
    checkOutput("t2_ready_low_while_held", {31'b0, bus.word_in_ready}, 32'h0);
    pushWord(32'h1b1a1918);
    repeat (15) @(negedge sender_clock);
    checkOutput("t2_gapless_run", 32'(max_run), 32'd12);

    $display("[TB] stall after lane 1");
    pushWord(32'h23222120);
    @(negedge sender_clock);
    checkOutput("t3_lane0", {24'b0, bus.data_in}, 32'h20);
    @(negedge sender_clock);
    checkOutput("t3_lane1", {24'b0, bus.data_in}, 32'h21);
    bus.data_in_used = PW'(FT);
    for (int i = 0; i < 5; i++) begin
      @(negedge sender_clock);
      checkOutput("t3_stalled_enable", {31'b0, bus.data_in_enable}, 32'h0);
      checkOutput("t3_stalled_data_hold", {24'b0, bus.data_in}, 32'h21);
    end
    bus.data_in_used = '0;
    @(negedge sender_clock);
    checkOutput("t3_resume_lane2", {24'b0, bus.data_in}, 32'h22);
    @(negedge sender_clock);
    checkOutput("t3_lane3", {24'b0, bus.data_in}, 32'h23);
    repeat (2) @(negedge sender_clock);

    bus.data_in_used = PW'(FT - 1);
    pushWord(32'h33323130);
    for (int i = 0; i < LANES; i++) begin
      @(negedge sender_clock);
      checkOutput("t3_below_threshold_enable", {31'b0, bus.data_in_enable}, 32'h1);
      checkOutput("t3_below_threshold_data", {24'b0, bus.data_in}, 32'h30 + 32'(i));
    end
    bus.data_in_used = '0;
    repeat (2) @(negedge sender_clock);

    $display("[TB] reset mid-word");
    pushWord(32'h43424140);
    pushWord(32'h53525150);
    @(negedge sender_clock);
    checkOutput("t4_lane1", {24'b0, bus.data_in}, 32'h41);
    @(negedge sender_clock);
    checkOutput("t4_lane2", {24'b0, bus.data_in}, 32'h42);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t4_async_data", {24'b0, bus.data_in}, 32'h0);
    checkOutput("t4_async_enable", {31'b0, bus.data_in_enable}, 32'h0);
    checkOutput("t4_async_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("t4_async_ready", {31'b0, bus.word_in_ready}, 32'h0);
    repeat (2) @(negedge sender_clock);
    reset = 1'b0;
    @(negedge sender_clock);
    pushWord(32'h63626160);
    for (int i = 0; i < LANES; i++) begin
      @(negedge sender_clock);
      checkOutput("t4_new_word_lane", {24'b0, bus.data_in}, 32'h60 + 32'(i));
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge sender_clock);
      checkOutput("t4_held_word_dropped", {31'b0, bus.data_in_enable}, 32'h0);
    end

    $display("[TB] random traffic");
    start_bytes = bytes_seen;
    sent = 0;
    cycles = 0;
    rand_word = $urandom;
    while (sent < RANDOM_WORDS && cycles < 60000) begin
      pick = $urandom_range(0, 9);
      if (pick < 5)       used_r = '0;
      else if (pick == 5) used_r = PW'(FT - 1);
      else if (pick == 6) used_r = PW'(FT);
      else if (pick == 7) used_r = PW'($urandom_range(FT, 2**PW - 1));
      else                used_r = PW'($urandom_range(0, FT - 1));
      valid_r = ($urandom_range(0, 3) != 0);
      applyStimulus(rand_word, valid_r, used_r);
      if (valid_r && bus.word_in_ready) begin
        sent++;
        rand_word = $urandom;
      end
      @(negedge sender_clock);
      cycles++;
    end
    if (sent < RANDOM_WORDS) begin
      assertions++;
      failures++;
      $display("[TB] FAIL random_budget: accepted %0d words, required %0d", sent, RANDOM_WORDS);
    end
    applyStimulus('0, 1'b0, '0);
    repeat (20) @(negedge sender_clock);
    checkOutput("random_byte_count", 32'(bytes_seen - start_bytes), 32'(sent * LANES));
`ifdef WORD_SERIALIZER_STATS_EN
    checkOutput("stats_total", {16'b0, words_sent}, {16'b0, 16'(sent + 1)});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
